// File: rtl/apb_dram_csr_pkg.sv
// Shared constants for the DRAM controller CSR block: register map, reset values
// and APB completer FSM states.
package apb_dram_csr_pkg;

  localparam logic [15:0] AddrCtrl    = 16'h0000;
  localparam logic [15:0] AddrTrcd    = 16'h0002;
  localparam logic [15:0] AddrTrp     = 16'h0004;
  localparam logic [15:0] AddrTrefi   = 16'h0006;
  localparam logic [15:0] AddrCmdAddr = 16'h0008;
  localparam logic [15:0] AddrCmdData = 16'h000A;
  localparam logic [15:0] AddrCmdGo   = 16'h000C;
  localparam logic [15:0] AddrStatus  = 16'h000E;
  localparam logic [15:0] AddrRdData  = 16'h0010;

  localparam logic [1:0]  RstCtrl     = 2'b00;
  localparam logic [3:0]  RstTrcd     = 4'h3;
  localparam logic [3:0]  RstTrp      = 4'h3;
  localparam logic [15:0] RstTrefi    = 16'h0618;

  typedef enum logic [1:0] {StIdle, StWait, StResp} apb_state_e;

endpackage

// File: rtl/apb_completer_fsm.sv
// APB access-phase timing: WAIT_CYCLES wait states, then a single pready cycle
// that doubles as the commit strobe for register side effects.
module apb_completer_fsm
  import apb_dram_csr_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic commit
);

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

  apb_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          cnt_d   = WaitInit;
          state_d = (WaitInit == 3'd0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          // Leave for RESP on the cycle the count reaches zero.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pready = (state_q == StResp);
  assign commit = (state_q == StResp) && psel && penable;

endmodule

// File: rtl/apb_dram_csr.sv
// APB CSR block for a DRAM controller: timing config registers plus a
// single-outstanding command launcher with read-data capture.
module apb_dram_csr
  import apb_dram_csr_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        cfg_enable,
  output logic        cfg_refresh_en,
  output logic [3:0]  cfg_trcd,
  output logic [3:0]  cfg_trp,
  output logic [15:0] cfg_trefi,
  output logic        cmd_valid,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  input  logic        init_done
);

  logic        commit;
  logic [1:0]  ctrl_q;
  logic [3:0]  trcd_q, trp_q;
  logic [15:0] trefi_q, caddr_q, cdata_q, rd_data_q;
  logic        busy_q, rd_valid_q, rd_out_q;
  logic        cmd_valid_q, cmd_write_q;
  logic [15:0] cmd_addr_q, cmd_wdata_q;

  apb_completer_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_fsm (
    .pclk   (pclk),
    .preset (preset),
    .psel   (psel),
    .penable(penable),
    .pready (pready),
    .commit (commit)
  );

  logic        mapped, err;
  logic [15:0] rdata;

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (paddr)
      AddrCtrl:    rdata = {14'b0, ctrl_q};
      AddrTrcd:    rdata = {12'b0, trcd_q};
      AddrTrp:     rdata = {12'b0, trp_q};
      AddrTrefi:   rdata = trefi_q;
      AddrCmdAddr: rdata = caddr_q;
      AddrCmdData: rdata = cdata_q;
      AddrCmdGo:   rdata = '0;
      AddrStatus:  rdata = {13'b0, init_done, rd_valid_q, busy_q};
      AddrRdData:  rdata = rd_data_q;
      default:     mapped = 1'b0;
    endcase
    err = !mapped || paddr[0]
        || (pwrite && (paddr == AddrStatus || paddr == AddrRdData))
        || (!pwrite && paddr == AddrCmdGo)
        || (pwrite && paddr == AddrCmdGo && pwdata[0] && (busy_q || !ctrl_q[0]));
  end

  assign pslverr = pready && err;
  assign prdata  = (pready && !err) ? rdata : '0;

  logic wr_ok, rd_ok, launch, handshake, rsp_take;
  assign wr_ok     = commit && pwrite && !err;
  assign rd_ok     = commit && !pwrite && !err;
  assign launch    = wr_ok && (paddr == AddrCmdGo) && pwdata[0];
  assign handshake = cmd_valid_q && cmd_ready;
  assign rsp_take  = rsp_valid && rd_out_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q      <= RstCtrl;
      trcd_q      <= RstTrcd;
      trp_q       <= RstTrp;
      trefi_q     <= RstTrefi;
      caddr_q     <= '0;
      cdata_q     <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_out_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      if (wr_ok) begin
        case (paddr)
          AddrCtrl:    ctrl_q  <= pwdata[1:0];
          AddrTrcd:    trcd_q  <= pwdata[3:0];
          AddrTrp:     trp_q   <= pwdata[3:0];
          AddrTrefi:   trefi_q <= pwdata;
          AddrCmdAddr: caddr_q <= pwdata;
          AddrCmdData: cdata_q <= pwdata;
          default: ;
        endcase
      end
      // launch can only fire while idle, so it never overlaps a handshake or response.
      if (launch) begin
        busy_q      <= 1'b1;
        cmd_valid_q <= 1'b1;
        cmd_write_q <= pwdata[1];
        cmd_addr_q  <= caddr_q;
        cmd_wdata_q <= cdata_q;
      end else if (handshake) begin
        cmd_valid_q <= 1'b0;
        if (cmd_write_q) busy_q <= 1'b0;
        else             rd_out_q <= 1'b1;
      end
      if (rsp_take) begin
        rd_data_q  <= rsp_rdata;
        rd_valid_q <= 1'b1;
        busy_q     <= 1'b0;
        rd_out_q   <= 1'b0;
      end else if (rd_ok && paddr == AddrRdData) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_enable     = ctrl_q[0];
  assign cfg_refresh_en = ctrl_q[1];
  assign cfg_trcd       = trcd_q;
  assign cfg_trp        = trp_q;
  assign cfg_trefi      = trefi_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_write      = cmd_write_q;
  assign cmd_addr       = cmd_addr_q;
  assign cmd_wdata      = cmd_wdata_q;

endmodule
